// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: sampled I2C pad inputs and SDA pull-low enable between pad ring and target.
interface i2c_target_regs_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;
  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a 16 x 8-bit register file, auto-incrementing pointer and local read port.
module i2c_target_regs #(
  parameter logic [6:0]   TARGET_ADDR = 7'h50,
  parameter logic [127:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  i2c_target_regs_if.slave bus,
  input  logic [3:0]       loc_addr,
  output logic [7:0]       loc_rdata,
  output logic             wr_pulse,
  output logic [3:0]       wr_index,
  output logic             busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d, bit_q, bit_d;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, ptr_q, ptr_d, wri_q, wri_d;
  logic [6:0] sh_q, sh_d;
  logic oe_q, oe_d, busy_q, busy_d, wrp_q, wrp_d;
  logic [15:0][7:0] regs_q, regs_d;
  logic [7:0] byte_w, rd_w;
  assign byte_w       = {sh_q, bit_q};
  assign rd_w         = regs_q[ptr_q];
  assign loc_rdata    = regs_q[loc_addr];
  assign bus.sda_oe   = oe_q;
  assign busy         = busy_q;
  assign wr_pulse     = wrp_q;
  assign wr_index     = wri_q;
  // Stages: [0],[1] synchronize, [2] holds the previous value; events are registered once more
  always_comb begin
    scl_d   = {scl_q[1:0], bus.scl_i};
    sda_d   = {sda_q[1:0], bus.sda_i};
    rise_d  = scl_q[1] & ~scl_q[2];
    fall_d  = ~scl_q[1] & scl_q[2];
    start_d = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    stop_d  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    bit_d   = sda_q[1];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sh_d    = sh_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wrp_d   = 1'b0;
    wri_d   = wri_q;
    regs_d  = regs_q;
    if (start_q) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else if (stop_q) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (rise_q) begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          sh_d  = byte_w[6:0];
          cnt_d = (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (state_q == ADDR) begin
              state_d = (byte_w[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
              busy_d  = (byte_w[7:1] == TARGET_ADDR);
            end else if (state_q == PTR) begin
              ptr_d   = byte_w[3:0];
              state_d = PTR_ACK;
            end else begin
              regs_d[ptr_q] = byte_w;
              wrp_d   = 1'b1;
              wri_d   = ptr_q;
              ptr_d   = ptr_q + 4'd1;
              state_d = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          cnt_d   = (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
          state_d = (cnt_q == 4'd7) ? RDATA_ACK : RDATA;
        end
        RDATA_ACK: begin
          // cnt=1 marks "controller ACKed, reload on the next fall"
          ptr_d   = ptr_q + 4'd1;
          state_d = bit_q ? IGNORE : RDATA_ACK;
          busy_d  = bit_q ? 1'b0 : busy_q;
          cnt_d   = bit_q ? cnt_q : 4'd1;
        end
        default: ;
      endcase
    end else if (fall_q) begin
      case (state_q)
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // First fall drives the ACK, the second one ends it and enters the next phase
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            cnt_d   = 4'd0;
            state_d = (state_q != ADDR_ACK) ? WDATA : (sh_q[0] ? RDATA : PTR);
            oe_d    = (state_d == RDATA) ? ~rd_w[7] : 1'b0;
            sh_d    = (state_d == RDATA) ? rd_w[6:0] : sh_q;
          end
        end
        RDATA: begin
          oe_d = ~sh_q[6];
          sh_d = {sh_q[5:0], 1'b0};
        end
        RDATA_ACK: begin
          state_d = (cnt_q == 4'd1) ? RDATA : RDATA_ACK;
          oe_d    = (cnt_q == 4'd1) ? ~rd_w[7] : 1'b0;
          sh_d    = (cnt_q == 4'd1) ? rd_w[6:0] : sh_q;
          cnt_d   = 4'd0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      bit_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 4'd0;
      sh_q    <= 7'd0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrp_q   <= 1'b0;
      wri_q   <= 4'd0;
      regs_q  <= RESET_VAL;
    end else begin
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      bit_q   <= bit_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sh_q    <= sh_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      wrp_q   <= wrp_d;
      wri_q   <= wri_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C controller model exercising writes, wrap, reads, NACK, aborts and reset.
module tb_i2c_target_regs;
  localparam int Q = 80;
  localparam logic [127:0] RV = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [3:0] loc_addr = 4'd0;
  logic [7:0] loc_rdata;
  logic wr_pulse, busy;
  logic [3:0] wr_index;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int wide = 0;
  logic prev_p = 1'b0;
  logic [3:0] idx_log [$];
  i2c_target_regs_if ifc();
  assign ifc.scl_i = m_scl;
  assign ifc.sda_i = m_sda & ~ifc.sda_oe;
  i2c_target_regs #(.TARGET_ADDR(7'h50), .RESET_VAL(RV)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc.slave), .loc_addr(loc_addr),
    .loc_rdata(loc_rdata), .wr_pulse(wr_pulse), .wr_index(wr_index), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    prev_p <= wr_pulse;
    if (wr_pulse) begin
      pulses <= pulses + 1;
      idx_log.push_back(wr_index);
    end
    if (wr_pulse && prev_p) wide <= wide + 1;
  end
  function automatic logic [7:0] rv(input int i);
    logic [3:0] n;
    n = 4'(i);
    return {~n, n};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q; #Q;
  endtask
  task automatic clk_bit(input logic b, output logic r);
    m_sda = b; #Q; m_scl = 1'b1; #Q; r = ifc.sda_i; #Q; m_scl = 1'b0; #Q;
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, ack);
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    logic [7:0] v;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      v[i] = r;
    end
    clk_bit(nack, r);
    d = v;
  endtask
  task automatic loc_check(input string tag, input int a, input logic [7:0] exp);
    loc_addr = 4'(a);
    #10;
    check(tag, {24'd0, loc_rdata}, {24'd0, exp});
  endtask
  initial begin
    logic ack;
    logic [7:0] d;
    #20;
    check("rst_sda_oe", {31'd0, ifc.sda_oe}, 0);
    check("rst_wr_pulse", {31'd0, wr_pulse}, 0);
    check("rst_wr_index", {28'd0, wr_index}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    #20 reset_n = 1'b1;
    #40;
    for (int i = 0; i < 16; i++) loc_check("rst_reg", i, rv(i));
    i2c_start();
    write_byte(8'hA0, ack); check("w1_ack_addr", {31'd0, ack}, 0);
    check("w1_busy", {31'd0, busy}, 1);
    write_byte(8'h03, ack); check("w1_ack_ptr", {31'd0, ack}, 0);
    write_byte(8'h5A, ack); check("w1_ack_data", {31'd0, ack}, 0);
    i2c_stop();
    check("w1_busy_after_stop", {31'd0, busy}, 0);
    check("w1_pulses", pulses, 1);
    check("w1_index", {28'd0, idx_log[0]}, 3);
    loc_check("w1_reg3", 3, 8'h5A);
    i2c_start();
    write_byte(8'hA0, ack); check("w2_ack_addr", {31'd0, ack}, 0);
    write_byte(8'h0F, ack); check("w2_ack_ptr", {31'd0, ack}, 0);
    write_byte(8'h11, ack); check("w2_ack_d0", {31'd0, ack}, 0);
    write_byte(8'h22, ack); check("w2_ack_d1", {31'd0, ack}, 0);
    i2c_stop();
    check("w2_pulses", pulses, 3);
    check("w2_index0", {28'd0, idx_log[1]}, 15);
    check("w2_index1", {28'd0, idx_log[2]}, 0);
    loc_check("w2_reg15", 15, 8'h11);
    loc_check("w2_reg0", 0, 8'h22);
    i2c_start();
    write_byte(8'hA0, ack); check("r1_ack_waddr", {31'd0, ack}, 0);
    write_byte(8'h02, ack); check("r1_ack_ptr", {31'd0, ack}, 0);
    i2c_start();
    write_byte(8'hA1, ack); check("r1_ack_raddr", {31'd0, ack}, 0);
    read_byte(1'b0, d); check("r1_byte0", {24'd0, d}, {24'd0, rv(2)});
    read_byte(1'b0, d); check("r1_byte1", {24'd0, d}, 32'h5A);
    read_byte(1'b1, d); check("r1_byte2", {24'd0, d}, {24'd0, rv(4)});
    check("r1_sda_released", {31'd0, ifc.sda_oe}, 0);
    check("r1_busy_after_nack", {31'd0, busy}, 0);
    i2c_stop();
    i2c_start();
    write_byte(8'hA1, ack); check("r2_ack_raddr", {31'd0, ack}, 0);
    read_byte(1'b1, d); check("r2_ptr_persist", {24'd0, d}, {24'd0, rv(5)});
    i2c_stop();
    check("r_no_pulses", pulses, 3);
    i2c_start();
    write_byte(8'hA4, ack); check("na_no_ack", {31'd0, ack}, 1);
    check("na_busy", {31'd0, busy}, 0);
    write_byte(8'h01, ack); check("na_data_no_ack", {31'd0, ack}, 1);
    check("na_busy2", {31'd0, busy}, 0);
    i2c_stop();
    check("na_no_pulse", pulses, 3);
    loc_check("na_reg1", 1, rv(1));
    i2c_start();
    write_byte(8'hA0, ack); check("na_next_ack", {31'd0, ack}, 0);
    write_byte(8'h07, ack);
    write_byte(8'h77, ack); check("na_next_data_ack", {31'd0, ack}, 0);
    i2c_stop();
    check("na_next_pulses", pulses, 4);
    check("na_next_index", {28'd0, idx_log[3]}, 7);
    loc_check("na_reg7", 7, 8'h77);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h08, ack); check("ab_ack_ptr", {31'd0, ack}, 0);
    for (int i = 0; i < 4; i++) clk_bit(1'b0, ack);
    i2c_stop();
    check("ab_no_pulse", pulses, 4);
    check("ab_sda_oe", {31'd0, ifc.sda_oe}, 0);
    check("ab_busy", {31'd0, busy}, 0);
    loc_check("ab_reg8", 8, rv(8));
    i2c_start();
    write_byte(8'hA1, ack); check("rs_ack", {31'd0, ack}, 0);
    check("rs_drive_zero", {31'd0, ifc.sda_oe}, 1);
    reset_n = 1'b0;
    #1;
    check("rs_async_release", {31'd0, ifc.sda_oe}, 0);
    check("rs_busy", {31'd0, busy}, 0);
    check("rs_wr_index", {28'd0, wr_index}, 0);
    #19 reset_n = 1'b1;
    m_scl = 1'b1; #Q;
    loc_check("rs_reg3", 3, rv(3));
    loc_check("rs_reg15", 15, rv(15));
    loc_check("rs_reg7", 7, rv(7));
    i2c_start();
    write_byte(8'hA1, ack); check("rs_read_ack", {31'd0, ack}, 0);
    read_byte(1'b1, d); check("rs_ptr_zero", {24'd0, d}, {24'd0, rv(0)});
    i2c_stop();
    check("pulse_width", wide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) holding a 16 x 8-bit register file, addressable from an external I2C controller. It is the other end of the SoC's IIC controller: board-level test masters and the Nios V IIC master in loopback both read and write it. A local side exposes the register contents and a write-event strobe to fabric logic, for example to drive LEDs or mirror DIP switches. Open-drain pads live at the top level; this block only sees sampled inputs and a pull-low enable.

## Interface
- TARGET_ADDR, 7'h50, 7-bit I2C address this block answers to
- RESET_VAL, 128'h0, reset contents of the register file, reg[i] = RESET_VAL[8*i+7:8*i]

- clk  in  1  system clock; must be at least 20x the SCL frequency
- reset_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- scl_i  in  1  SCL pad input, asynchronous
- sda_i  in  1  SDA pad input, asynchronous
- sda_oe  out  1  1 = pull SDA low; 0 = release
- loc_addr  in  4  local read index
- loc_rdata  out  8  reg[loc_addr], combinational from the register file
- wr_pulse  out  1  one-clock strobe for each register written over I2C
- wr_index  out  4  register index written; valid with wr_pulse
- busy  out  1  1 from an addressed START until the next STOP or NACK exit

## Operation
- Input conditioning: scl_i and sda_i pass through 2-flop synchronizers, then a third "previous" flop. Edges are detected on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in any state, including mid-byte.
  - START or repeated START goes to ADDR with the bit counter cleared.
  - STOP goes to IDLE and releases SDA.
- Bits are sampled on the SCL rising edge, MSB first. The block changes sda_oe only on a detected SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits.
  - If bits[7:1] == TARGET_ADDR, go to ADDR_ACK and drive ACK (sda_oe=1) for one SCL period.
  - Otherwise go to IGNORE, with sda_oe held 0 until the next START or STOP.
- After the address ACK:
  - R/W = 0: go to PTR.
  - R/W = 1: go to RDATA and load the shift register with reg[ptr].
- PTR: receive 8 bits and set ptr <= byte[3:0]; bits [7:4] are ignored. ACK, then go to WDATA.
- WDATA: receive a byte. On the 8th SCL rise:
  - write reg[ptr];
  - assert wr_pulse with wr_index = ptr;
  - ptr <= ptr+1 mod 16 (wraps 15 -> 0).
  - Then ACK and return to WDATA.
- RDATA: drive bit = 0 as sda_oe=1 and bit = 1 as release, for 8 bits. Then release SDA and sample the controller ACK on the 9th SCL rise.
  - ACK (0): ptr <= ptr+1 mod 16, reload from the new ptr, continue in RDATA.
  - NACK (1): go to IGNORE; ptr is still incremented.
- ptr persists across transactions. A read with no preceding pointer write starts at the last ptr value.
- A write that arrives on the same clock as a local read of the same index: loc_rdata shows the old value that cycle and the new value the next cycle.

## Timing
- Reset values: sda_oe=0, wr_pulse=0, wr_index=0, busy=0, ptr=0, state=IDLE, reg file = RESET_VAL.
- Edge-detection latency: 3 clk from a pad transition to the internal edge event.
- sda_oe changes 1 clk after a detected SCL fall, which is 4 clk after the pad fall. Data is stable well before the next SCL rise given the 20x clock ratio.
- wr_pulse is asserted the clk after the detected 8th SCL rise of a WDATA byte, for exactly 1 clk. The register update is visible on loc_rdata in that same cycle.
- ACK drive: asserted on the SCL fall after bit 8, released on the SCL fall after the 9th clock.
- busy rises with ADDR_ACK entry and falls on the STOP or NACK->IGNORE transition.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous) and SDA is released. After reset_n deasserts, the block waits in IDLE for a fresh START.

## Test plan
- Write 0xA0, ptr 0x03, data 0x5A, STOP -> three ACKs; reg[3]=0x5A; one wr_pulse with wr_index=3; loc_addr=3 gives 0x5A.
- Write ptr 0x0F, data 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap); two wr_pulses with indices 15 then 0.
- Write ptr 0x02, repeated START, read 0xA1 with 3 bytes (ACK, ACK, NACK), STOP -> controller sees reg[2], reg[3], reg[4]; final ptr = 5; SDA released after the NACK.
- Address 0xA4 (0x52) -> no ACK (SDA high on 9th clock); no writes; busy stays 0; the next addressed START is served normally.
- STOP injected after 4 bits of a WDATA byte -> no register change, no wr_pulse, state IDLE, sda_oe=0.
- reset_n pulsed low while the block drives a read 0-bit -> sda_oe drops asynchronously; all regs return to RESET_VAL; ptr=0.
